// File: rtl/ibex_rf_ctrl_pkg.sv
// Shared types and sizing helpers for the register-file write-back control path.
package ibex_rf_ctrl_pkg;

    typedef enum logic {
        WB_SRC_EX  = 1'b0,
        WB_SRC_LSU = 1'b1
    } wb_src_e;

    localparam int unsigned RF_ADDR_W = 5;

    function automatic int unsigned rf_num_words(input bit rv32e);
        return rv32e ? 32'd16 : 32'd32;
    endfunction

endpackage

// File: rtl/ibex_rf_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register x1..x(NUM_WORDS-1),
// set by issue-stage allocation, cleared by the register-file write, wiped by flush.
module ibex_rf_scoreboard
    import ibex_rf_ctrl_pkg::*;
#(
    parameter bit RV32E = 1'b0
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 alloc_valid_i,
    input  logic [RF_ADDR_W-1:0] alloc_addr_i,
    input  logic                 clr_valid_i,
    input  logic [RF_ADDR_W-1:0] clr_addr_i,
    input  logic                 flush_i,
    input  logic [RF_ADDR_W-1:0] raddr_a_i,
    input  logic [RF_ADDR_W-1:0] raddr_b_i,
    output logic                 busy_a_o,
    output logic                 busy_b_o
);

    localparam int unsigned NUM_WORDS = rf_num_words(RV32E);

    // x0 has no storage; addresses outside 1..NUM_WORDS-1 never match the loops below.
    logic [NUM_WORDS-1:1] r_pending;
    logic [NUM_WORDS-1:1] w_pending_d;
    logic                 w_busy_a;
    logic                 w_busy_b;

    // Clear first so that a same-cycle alloc to the same register wins; flush overrides both.
    always_comb begin
        w_pending_d = r_pending;
        for (int unsigned i = 1; i < NUM_WORDS; i++) begin
            if (clr_valid_i && (clr_addr_i == RF_ADDR_W'(i))) begin
                w_pending_d[i] = 1'b0;
            end
            if (alloc_valid_i && (alloc_addr_i == RF_ADDR_W'(i))) begin
                w_pending_d[i] = 1'b1;
            end
        end
        if (flush_i) begin
            w_pending_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_d;
        end
    end

    always_comb begin
        w_busy_a = 1'b0;
        w_busy_b = 1'b0;
        for (int unsigned i = 1; i < NUM_WORDS; i++) begin
            if (raddr_a_i == RF_ADDR_W'(i)) begin
                w_busy_a = r_pending[i];
            end
            if (raddr_b_i == RF_ADDR_W'(i)) begin
                w_busy_b = r_pending[i];
            end
        end
    end

    assign busy_a_o = w_busy_a;
    assign busy_b_o = w_busy_b;

endmodule

// File: rtl/ibex_rf_wb_arbiter.sv
// Round-robin EX/LSU write-back arbiter with a registered register-file write port.
// Define IBEX_WB_SCOREBOARD_EN to build the pending-write scoreboard and busy outputs.
module ibex_rf_wb_arbiter
    import ibex_rf_ctrl_pkg::*;
#(
    parameter bit          RV32E     = 1'b0,
    parameter int unsigned DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 ex_valid_i,
    output logic                 ex_ready_o,
    input  logic [RF_ADDR_W-1:0] ex_addr_i,
    input  logic [DataWidth-1:0] ex_wdata_i,
    input  logic                 lsu_valid_i,
    output logic                 lsu_ready_o,
    input  logic [RF_ADDR_W-1:0] lsu_addr_i,
    input  logic [DataWidth-1:0] lsu_wdata_i,
    output logic [RF_ADDR_W-1:0] waddr_a_o,
    output logic [DataWidth-1:0] wdata_a_o,
    output logic                 we_a_o,
    input  logic                 alloc_valid_i,
    input  logic [RF_ADDR_W-1:0] alloc_addr_i,
    input  logic                 flush_i,
    input  logic [RF_ADDR_W-1:0] raddr_a_i,
    input  logic [RF_ADDR_W-1:0] raddr_b_i,
    output logic                 busy_a_o,
    output logic                 busy_b_o
);

    // Handshake: a request transfers in any cycle where valid and ready are both high;
    // ready is combinational from both valids and r_prio, and at most one ready is high.
    wb_src_e                r_prio;
    logic                   r_we;
    logic [RF_ADDR_W-1:0]   r_waddr;
    logic [DataWidth-1:0]   r_wdata;

    wb_src_e                w_src;
    logic                   w_contend;
    logic                   w_fire;
    logic                   w_legal;
    logic [RF_ADDR_W-1:0]   w_addr;
    logic [DataWidth-1:0]   w_data;

    always_comb begin
        w_contend = ex_valid_i & lsu_valid_i;
        if (w_contend) begin
            w_src = r_prio;
        end else if (lsu_valid_i) begin
            w_src = WB_SRC_LSU;
        end else begin
            w_src = WB_SRC_EX;
        end
    end

    assign ex_ready_o  = ex_valid_i  & (w_src == WB_SRC_EX);
    assign lsu_ready_o = lsu_valid_i & (w_src == WB_SRC_LSU);
    assign w_fire      = ex_ready_o | lsu_ready_o;
    assign w_addr      = (w_src == WB_SRC_LSU) ? lsu_addr_i  : ex_addr_i;
    assign w_data      = (w_src == WB_SRC_LSU) ? lsu_wdata_i : ex_wdata_i;
    // x0 and out-of-range RV32E targets are accepted but never written.
    assign w_legal     = (w_addr != '0) && !(RV32E && w_addr[RF_ADDR_W-1]);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_prio  <= WB_SRC_EX;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            if (w_contend) begin
                r_prio <= (r_prio == WB_SRC_EX) ? WB_SRC_LSU : WB_SRC_EX;
            end
            r_we <= w_fire & w_legal;
            if (w_fire) begin
                r_waddr <= w_addr;
                r_wdata <= w_data;
            end
        end
    end

    assign we_a_o    = r_we;
    assign waddr_a_o = r_waddr;
    assign wdata_a_o = r_wdata;

`ifdef IBEX_WB_SCOREBOARD_EN
    ibex_rf_scoreboard #(
        .RV32E(RV32E)
    ) u_scoreboard (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .alloc_valid_i(alloc_valid_i),
        .alloc_addr_i (alloc_addr_i),
        .clr_valid_i  (r_we),
        .clr_addr_i   (r_waddr),
        .flush_i      (flush_i),
        .raddr_a_i    (raddr_a_i),
        .raddr_b_i    (raddr_b_i),
        .busy_a_o     (busy_a_o),
        .busy_b_o     (busy_b_o)
    );
`else
    logic w_sb_unused;
    assign w_sb_unused = ^{alloc_valid_i, alloc_addr_i, flush_i, raddr_a_i, raddr_b_i};
    assign busy_a_o    = 1'b0;
    assign busy_b_o    = 1'b0;
`endif

endmodule

// File: doc/ibex_rf_wb_arbiter.md
# ibex_rf_wb_arbiter

Write-back arbiter and pending-write scoreboard for the core's flip-flop register file. It shares the register file's single write port between two requesters, the execute stage (EX) and the load-store unit (LSU), and presents one registered write to the register file. It also tracks which architectural registers have an outstanding write, so the issue stage can stall on read-after-write hazards.

## Interface
Parameters:
- RV32E, 0: when 1, 16 registers; addresses with bit 4 set are illegal.
- DataWidth, 32: register data width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- ex_valid_i  in  1  EX write-back request.
- ex_ready_o  out  1  EX request accepted this cycle.
- ex_addr_i  in  5  EX destination register.
- ex_wdata_i  in  DataWidth  EX write data.
- lsu_valid_i  in  1  LSU write-back request.
- lsu_ready_o  out  1  LSU request accepted this cycle.
- lsu_addr_i  in  5  LSU destination register.
- lsu_wdata_i  in  DataWidth  LSU write data.
- waddr_a_o  out  5  register file write address.
- wdata_a_o  out  DataWidth  register file write data.
- we_a_o  out  1  register file write enable.
- alloc_valid_i  in  1  issue stage marks a destination register as pending.
- alloc_addr_i  in  5  register being allocated.
- flush_i  in  1  clear all pending bits.
- raddr_a_i  in  5  issue-stage operand A address.
- raddr_b_i  in  5  issue-stage operand B address.
- busy_a_o  out  1  operand A has a pending write.
- busy_b_o  out  1  operand B has a pending write.

## Operation
- Handshake: a request transfers when valid and ready are both high in the same cycle. The ready outputs are combinational from the valid inputs and the priority state. At most one ready is high per cycle.
- A valid request must hold its address and data stable until it is accepted.
- Arbitration is round-robin over a 1-bit priority register, prio_q. prio_q = 0 favours EX; prio_q = 1 favours LSU.
- With a single valid requester, that requester is granted regardless of prio_q.
- When both requesters are valid, the favoured one is granted, and prio_q then points to the other requester.
- prio_q changes only on a contended grant.
- Output stage: the granted address and data are registered. we_a_o goes high the following cycle for exactly one cycle per grant.
- The register file always accepts a write, so the output stage never back-pressures the requesters.
- Writes to x0 are accepted (ready high), but we_a_o stays 0. The same applies to illegal RV32E addresses.
- Scoreboard: a pending bit per register, x1..x(NUM_WORDS-1). x0 and illegal addresses are never pending.
- alloc_valid_i sets the bit for alloc_addr_i at the next edge.
- A cycle with we_a_o = 1 clears the bit for waddr_a_o at the next edge.
- If an alloc and a clear target the same register in the same cycle, the alloc wins and the bit stays set.
- flush_i clears all bits at the next edge and overrides any alloc in the same cycle.
- busy_a_o / busy_b_o = pending[raddr] (combinational). Address 0 always reads 0.

## Timing
- Reset values: we_a_o 0, waddr_a_o 0, wdata_a_o 0, prio_q 0, all pending bits 0, busy_a_o and busy_b_o 0.
- ex_ready_o and lsu_ready_o are 0 while their valid inputs are 0.
- Latency:
  - The accept edge N produces we_a_o in cycle N+1.
  - The pending bit is cleared at edge N+2, so busy deasserts in cycle N+2.
  - Register file read data is valid from cycle N+2.
- Throughput: one write per cycle, back to back, with no bubble.
- Reset asserted mid-operation clears the output register and scoreboard asynchronously. A write in flight is lost, and no we_a_o pulse follows reset release.

## Configuration
- IBEX_WB_SCOREBOARD_EN defined: the scoreboard and its busy outputs operate as described above.
- Macro undefined: the scoreboard is not instantiated and busy_a_o and busy_b_o are tied to 0. alloc_valid_i, alloc_addr_i, flush_i, raddr_a_i and raddr_b_i are ignored. Arbitration and the output stage are unchanged.

## Structure
- Package ibex_rf_ctrl_pkg:
  - the wb_src_e enum (WB_SRC_EX = 0, WB_SRC_LSU = 1);
  - RF_ADDR_W = 5;
  - a function returning NUM_WORDS from RV32E.
- Sub-module ibex_rf_scoreboard holds the pending bits, the set/clear/flush priority logic and the two read ports. It is instantiated only under IBEX_WB_SCOREBOARD_EN.

## Test plan
- Reset then idle: all outputs 0; the EX write x5 = 0xDEADBEEF is accepted at cycle 1; we_a_o = 1 with waddr_a_o = 5 at cycle 2 only.
- Both requesters valid for 4 cycles, EX targeting x1 and LSU targeting x2: grants go EX, LSU, EX, LSU; waddr_a_o sequence is 1, 2, 1, 2.
- LSU write to x0 with data 0x1234: lsu_ready_o = 1, we_a_o stays 0.
- RV32E = 1, EX write to x17: accepted, we_a_o 0; alloc of x17 leaves busy 0.
- Alloc x7 in cycle 0, then raddr_a_i = 7: busy_a_o = 1 from cycle 1. EX writes x7 at cycle 3; busy_a_o drops in cycle 5. Alloc of x7 in the same cycle as the we_a_o clear keeps busy_a_o = 1.
- Alloc x3, x4, then flush_i together with alloc x9: all busy outputs 0 afterwards. With the macro undefined, busy outputs are 0 throughout.
